mem_req_arb: RTL
================

Name: mem_req_arb

Overview:
- Shares the single core memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Grants one request per handshake and records the winner in an in-order tag FIFO, so each response returns to its originator.
- Sits between the IFU/LSU fetch channels and the memory-side bypass buffer.
- All channels use vld/rdy handshakes; a transfer occurs on a cycle with vld & rdy.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- OUTS, 2, maximum outstanding transactions (tag FIFO depth, power of 2, ≥1).
- LSU_PRIO, 1, 1 = LSU fixed priority; 0 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ifu_req_vld  in  1  IFU request valid
- ifu_req_rdy  out  1  IFU request accepted
- ifu_req_addr  in  AW  fetch address
- ifu_rsp_vld  out  1  IFU response valid
- ifu_rsp_rdy  in  1  IFU response ready
- ifu_rsp_data  out  DW  instruction word
- ifu_rsp_err  out  1  bus error
- lsu_req_vld  in  1  LSU request valid
- lsu_req_rdy  out  1  LSU request accepted
- lsu_req_addr  in  AW  address
- lsu_req_wen  in  1  1 = write
- lsu_req_wdata  in  DW  write data
- lsu_req_wmask  in  DW/8  byte strobes
- lsu_rsp_vld  out  1  LSU response valid
- lsu_rsp_rdy  in  1  LSU response ready
- lsu_rsp_data  out  DW  read data
- lsu_rsp_err  out  1  bus error
- mem_req_vld  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts request
- mem_req_addr  out  AW  address
- mem_req_wen  out  1  write flag (0 for IFU)
- mem_req_wdata  out  DW  write data (0 for IFU)
- mem_req_wmask  out  DW/8  strobes (0 for IFU)
- mem_rsp_vld  in  1  memory response valid
- mem_rsp_rdy  out  1  response ready
- mem_rsp_data  in  DW  response data
- mem_rsp_err  in  1  response error

Behaviour:
- Clocking/reset: one clock, clk. rst is synchronous, active-high.
- Reset state: tag FIFO empty (count 0, pointers 0), lock cleared, round-robin pointer = IFU-next.
- Outputs after reset: mem_req_vld=0, ifu_rsp_vld=0, lsu_rsp_vld=0.
- Reset asserted mid-transaction discards all outstanding tags. Late memory responses after reset are handled as orphans (see below).
- Arbitration is combinational, with zero added latency. mem_req_vld = (ifu_req_vld | lsu_req_vld) & ~full.
- Winner selection:
  - Only one requester valid: that requester wins.
  - Both valid, LSU_PRIO=1: LSU wins.
  - Both valid, LSU_PRIO=0: the requester not granted last wins. The pointer updates only on mem handshake.
- Lock: if mem_req_vld=1 and mem_req_rdy=0, the winner is registered and held until the handshake. A newly arriving higher-priority requester cannot preempt it, so mem_req fields stay stable while stalled.
- Request ready: ifu_req_rdy = winner==IFU & mem_req_rdy & ~full. lsu_req_rdy is symmetric.
- Push: on mem handshake, push the winner tag (0 = IFU, 1 = LSU).
- Full: full = count==OUTS. When full, no request is issued, even if a pop occurs in the same cycle.
- Response routing: when not empty, the head tag selects the destination.
  - mem_rsp_data/err are passed to that destination's rsp outputs.
  - The destination's rsp_vld = mem_rsp_vld.
  - mem_rsp_rdy = the destination's rsp_rdy.
  - The non-selected rsp_vld is 0.
  - Pop on mem_rsp handshake.
- Orphan responses: if empty, mem_rsp_rdy=1, the response is discarded, and no rsp_vld is raised.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance. Pointers wrap modulo OUTS.
- Response latency: the response path is combinational, with zero added cycles.
- Error handling: mem_rsp_err is passed to the owner. No retry, and the tag is still popped.

Test Plan:
- IFU alone: 0x8000_0000 issued while mem_req_rdy=1 → mem_req_addr=0x8000_0000, wen=0. Response 0x0000_0013 → ifu_rsp_data=0x13, and lsu_rsp_vld stays 0.
- Contention, LSU_PRIO=1: both valid for 3 cycles, mem_req_rdy=1 → LSU is granted every cycle, and ifu_req_rdy=0 throughout.
- Contention, LSU_PRIO=0: both valid for 4 handshakes → grant order I, L, I, L (IFU first after reset).
- Lock: IFU is stalled with mem_req_rdy=0 for 3 cycles, and LSU asserts in cycle 2 → addr is held at the IFU value. IFU completes first, then LSU.
- Full with OUTS=2: two grants, no responses → mem_req_vld=0 on the third attempt. One response, then a retry → the request is issued one cycle later. Responses return L-data to LSU and I-data to IFU in issue order.
- Backpressure: lsu_rsp_rdy=0 for 2 cycles with the head tag = LSU → mem_rsp_rdy=0 and no pop. A response with an empty FIFO after reset → absorbed, with no rsp_vld.

Source files
------------

// File: rtl/mem_req_arb.sv
// mem_req_arb: shares one memory port between IFU and LSU and routes responses back in order through a tag FIFO
module mem_req_arb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int OUTS     = 2,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_vld,
  output logic            ifu_req_rdy,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_rsp_vld,
  input  logic            ifu_rsp_rdy,
  output logic [DW-1:0]   ifu_rsp_data,
  output logic            ifu_rsp_err,
  input  logic            lsu_req_vld,
  output logic            lsu_req_rdy,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic            lsu_req_wen,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wmask,
  output logic            lsu_rsp_vld,
  input  logic            lsu_rsp_rdy,
  output logic [DW-1:0]   lsu_rsp_data,
  output logic            lsu_rsp_err,
  output logic            mem_req_vld,
  input  logic            mem_req_rdy,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_wen,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wmask,
  input  logic            mem_rsp_vld,
  output logic            mem_rsp_rdy,
  input  logic [DW-1:0]   mem_rsp_data,
  input  logic            mem_rsp_err
);
  localparam int PW = OUTS > 1 ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);
  logic [OUTS-1:0] tags_q, tags_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lock_q, lock_d, lock_sel_q, lock_sel_d, rr_q, rr_d;
  logic            full, empty, hold, sel, head, req_hs, rsp_hs;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(OUTS - 1) ? '0 : p + 1'b1;
  endfunction
  assign full  = cnt_q == CW'(OUTS);
  assign empty = cnt_q == '0;
  assign head  = tags_q[rptr_q];
  // a stalled grant stays with its requester only while that requester keeps asking
  assign hold  = lock_q & (lock_sel_q ? lsu_req_vld : ifu_req_vld);
  // sel=1 means LSU wins; rr_q=1 means LSU is next in round-robin order
  assign sel   = hold ? lock_sel_q : lsu_req_vld & (~ifu_req_vld | LSU_PRIO | rr_q);
  assign mem_req_vld   = (ifu_req_vld | lsu_req_vld) & ~full;
  assign mem_req_addr  = sel ? lsu_req_addr : ifu_req_addr;
  assign mem_req_wen   = sel & lsu_req_wen;
  assign mem_req_wdata = sel ? lsu_req_wdata : '0;
  assign mem_req_wmask = sel ? lsu_req_wmask : '0;
  assign ifu_req_rdy   = ~sel & mem_req_rdy & ~full;
  assign lsu_req_rdy   = sel & mem_req_rdy & ~full;
  assign req_hs        = mem_req_vld & mem_req_rdy;
  assign ifu_rsp_vld   = mem_rsp_vld & ~empty & ~head;
  assign lsu_rsp_vld   = mem_rsp_vld & ~empty & head;
  assign ifu_rsp_data  = mem_rsp_data;
  assign lsu_rsp_data  = mem_rsp_data;
  assign ifu_rsp_err   = mem_rsp_err & ~empty & ~head;
  assign lsu_rsp_err   = mem_rsp_err & ~empty & head;
  assign mem_rsp_rdy   = empty | (head ? lsu_rsp_rdy : ifu_rsp_rdy);
  assign rsp_hs        = mem_rsp_vld & mem_rsp_rdy & ~empty;
  // next-state for tag FIFO, lock and round-robin pointer
  always_comb begin
    tags_d          = tags_q;
    tags_d[wptr_q]  = req_hs ? sel : tags_q[wptr_q];
    wptr_d          = req_hs ? inc(wptr_q) : wptr_q;
    rptr_d          = rsp_hs ? inc(rptr_q) : rptr_q;
    cnt_d           = cnt_q + CW'(req_hs) - CW'(rsp_hs);
    lock_d          = mem_req_vld & ~mem_req_rdy;
    lock_sel_d      = sel;
    rr_d            = req_hs ? ~sel : rr_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tags_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      tags_q     <= tags_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      rr_q       <= rr_d;
    end
  end
endmodule
